// File: rtl/even_parity_serial_tx.sv
// Even-parity serial transmitter: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Optional feature macro PARITY_ERR_INJECT_EN adds err_inject to invert the parity of one frame.
module even_parity_serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
`ifdef PARITY_ERR_INJECT_EN
  input  logic              err_inject,
`endif
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_out,
  output logic              done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Handshake: a word is accepted on a rising edge where valid_in && ready;
  // ready is high only in IDLE, and valid_in/data_in are ignored otherwise.
  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  idx, idx_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              parity_d;
  logic              done_d;
  logic              tx_d;
  logic              bit_last;
  logic              err_bit;

`ifdef PARITY_ERR_INJECT_EN
  assign err_bit = err_inject;
`else
  assign err_bit = 1'b0;
`endif

  assign bit_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      parity_out <= 1'b0;
      done       <= 1'b0;
      tx         <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      idx        <= idx_d;
      shreg      <= shreg_d;
      parity_out <= parity_d;
      done       <= done_d;
      tx         <= tx_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    idx_d    = idx;
    shreg_d  = shreg;
    parity_d = parity_out;
    done_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_in) begin
          state_d  = S_START;
          cnt_d    = '0;
          idx_d    = '0;
          shreg_d  = data_in;
          parity_d = (^data_in) ^ err_bit;
        end
      end
      S_START: begin
        if (bit_last) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_last) begin
          cnt_d   = '0;
          shreg_d = shreg >> 1;
          if (idx == IDX_LAST) state_d = S_PARITY;
          else                 idx_d   = idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is computed from the next state so the line register changes exactly at bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase
    busy  = (state != S_IDLE);
    ready = (state == S_IDLE);
  end

endmodule
